// File: rtl/sqrt_pkg.sv
// Shared definitions for the integer square-root controller: widths,
// control-bus bit positions, status-bus field slices and the FSM state type.
package sqrt_pkg;

    localparam int DATA_W = 8;
    localparam int S_W    = DATA_W + 1;
    localparam int CTRL_W = 10;
    localparam int STAT_W = S_W + DATA_W;

    // Control bus bit positions
    localparam int CTRL_INIT  = 0;  // s<=4, d<=2
    localparam int CTRL_LD_S  = 1;  // s <= reg1 + reg2
    localparam int CTRL_LD_D  = 2;  // d <= reg1 + reg2
    localparam int CTRL_OUT   = 3;  // r / dt_o <= d >> 1
    localparam int CTRL_LD_R1 = 4;  // reg1 <= sel
    localparam int CTRL_LD_R2 = 5;  // reg2 <= sel
    localparam int CTRL_SEL_D = 6;  // sel = d
    localparam int CTRL_SEL_2 = 7;  // sel = constant 2
    localparam int CTRL_SEL_S = 8;  // sel = s
    localparam int CTRL_SEL_1 = 9;  // sel = constant 1

    // Status bus field slices: {x, s}
    localparam int STAT_S_LSB = 0;
    localparam int STAT_S_MSB = S_W - 1;
    localparam int STAT_X_LSB = S_W;
    localparam int STAT_X_MSB = S_W + DATA_W - 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_CMP,
        ST_D1,
        ST_D2,
        ST_D3,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_FIN
    } state_t;

    // One-hot control word with a single bit set
    function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
        logic [CTRL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sqrt_ctrl.sv
// Sequencing FSM for the 8-bit odd-increment square-root datapath.
// Loop: s=4, d=2; while (s <= x) { d += 2; s += d + 1; }; r = d >> 1.
// Each loop pass is ten cycles (CMP plus D1..S6); a watchdog aborts with
// err_o if the loop runs more than MAX_ITER passes.
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = 16
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [STAT_W-1:0] bus_proc,
    output logic              busy_o,
    output logic [CTRL_W-1:0] bus_ctrl,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(MAX_ITER + 1);
    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  iter_reg,  iter_next;
    logic              busy_reg,  busy_next;
    logic              done_reg,  done_next;
    logic              err_reg,   err_next;

    logic [S_W-1:0]    s_val;
    logic [DATA_W-1:0] x_val;
    logic              s_gt_x;

    assign s_val  = bus_proc[STAT_S_MSB:STAT_S_LSB];
    assign x_val  = bus_proc[STAT_X_MSB:STAT_X_LSB];
    // 9-bit unsigned compare against zero-extended x
    assign s_gt_x = (s_val > {1'b0, x_val});

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign err_o  = err_reg;

    // State, iteration counter and handshake outputs register
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
            iter_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, counter and handshake logic
    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_INIT;
                    busy_next  = 1'b1;
                end
            end
            ST_INIT: begin
                state_next = ST_CMP;
                iter_next  = '0;
            end
            ST_CMP: begin
                if (s_gt_x) begin
                    state_next = ST_FIN;
                end else if (iter_reg == ITER_LIMIT) begin
                    // Runaway loop: abandon without producing a result
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    err_next   = 1'b1;
                end else begin
                    state_next = ST_D1;
                    iter_next  = iter_reg + 1'b1;
                end
            end
            ST_D1:   state_next = ST_D2;
            ST_D2:   state_next = ST_D3;
            ST_D3:   state_next = ST_S1;
            ST_S1:   state_next = ST_S2;
            ST_S2:   state_next = ST_S3;
            ST_S3:   state_next = ST_S4;
            ST_S4:   state_next = ST_S5;
            ST_S5:   state_next = ST_S6;
            ST_S6:   state_next = ST_CMP;
            ST_FIN: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Moore decode of datapath commands; at most one select bit per state
    always_comb begin
        bus_ctrl = '0;
        case (state_reg)
            ST_INIT: bus_ctrl = ctrl_bit(CTRL_INIT);
            ST_D1:   bus_ctrl = ctrl_bit(CTRL_SEL_D) | ctrl_bit(CTRL_LD_R1);
            ST_D2:   bus_ctrl = ctrl_bit(CTRL_SEL_2) | ctrl_bit(CTRL_LD_R2);
            ST_D3:   bus_ctrl = ctrl_bit(CTRL_LD_D);
            ST_S1:   bus_ctrl = ctrl_bit(CTRL_SEL_S) | ctrl_bit(CTRL_LD_R1);
            ST_S2:   bus_ctrl = ctrl_bit(CTRL_SEL_D) | ctrl_bit(CTRL_LD_R2);
            ST_S3:   bus_ctrl = ctrl_bit(CTRL_LD_S);
            ST_S4:   bus_ctrl = ctrl_bit(CTRL_SEL_S) | ctrl_bit(CTRL_LD_R1);
            ST_S5:   bus_ctrl = ctrl_bit(CTRL_SEL_1) | ctrl_bit(CTRL_LD_R2);
            ST_S6:   bus_ctrl = ctrl_bit(CTRL_LD_S);
            ST_FIN:  bus_ctrl = ctrl_bit(CTRL_OUT);
            default: bus_ctrl = '0;
        endcase
    end

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Bench for sqrt_ctrl paired with a behavioural model of the datapath.
module tb_sqrt_ctrl;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic [16:0] bus_proc;
    logic        busy_o;
    logic [9:0]  bus_ctrl;
    logic        done_o;
    logic        err_o;

    logic [7:0]  dt_i;
    logic        hold_s_zero;

    sqrt_ctrl dut (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .start_i  (start_i),
        .bus_proc (bus_proc),
        .busy_o   (busy_o),
        .bus_ctrl (bus_ctrl),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- datapath model ----------------
    logic [7:0] dp_x, dp_r;
    logic [8:0] dp_s, dp_d, dp_r1, dp_r2, dp_sel;

    always_comb begin
        dp_sel = 9'd0;
        if (bus_ctrl[6])      dp_sel = dp_d;
        else if (bus_ctrl[7]) dp_sel = 9'd2;
        else if (bus_ctrl[8]) dp_sel = dp_s;
        else if (bus_ctrl[9]) dp_sel = 9'd1;
    end

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            dp_x  <= '0;
            dp_r  <= '0;
            dp_s  <= '0;
            dp_d  <= '0;
            dp_r1 <= '0;
            dp_r2 <= '0;
        end else begin
            if (!busy_o)     dp_x  <= dt_i;
            if (bus_ctrl[0]) begin
                dp_s <= 9'd4;
                dp_d <= 9'd2;
            end
            if (bus_ctrl[4]) dp_r1 <= dp_sel;
            if (bus_ctrl[5]) dp_r2 <= dp_sel;
            if (bus_ctrl[1]) dp_s  <= dp_r1 + dp_r2;
            if (bus_ctrl[2]) dp_d  <= dp_r1 + dp_r2;
            if (bus_ctrl[3]) dp_r  <= dp_d[8:1];
        end
    end

    assign bus_proc = {dp_x, (hold_s_zero ? 9'd0 : dp_s)};

    // ---------------- scoreboard and checking ----------------
    typedef struct {
        int x;
        int r;
        int cyc;
    } exp_t;

    typedef struct {
        int x;
        int r;
        int lat;
    } vec_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   err_cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // Advance one cycle, sample on the falling edge and retire any result
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (done_o) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                $display("done x=%0d r=%0d cyc=%0d", e.x, dp_r, cyc);
                check($sformatf("result_x%0d", e.x), int'(dp_r), e.r);
                check($sformatf("latency_x%0d", e.x), cyc, e.cyc);
            end
        end
        if (err_o) begin
            err_cnt++;
            err_cyc = cyc;
            $display("err cyc=%0d", cyc);
        end
        if (done_o && err_o) check("done_err_overlap", 1, 0);
    endtask

    task automatic launch(input int x, input int r, input int lat);
        dt_i    = 8'(x);
        start_i = 1'b1;
        sb_q.push_back('{x, r, cyc + lat});
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    function automatic int isqrt(input int x);
        int i;
        i = 0;
        while ((i + 1) * (i + 1) <= x) i++;
        return i;
    endfunction

    vec_t       vecs [12];
    logic [9:0] seq3 [3];
    logic [9:0] seq4 [13];

    initial begin
        int r_exp, t0, e0, d0, n;

        vecs = '{
            '{3,   1,  4}, '{4,   2, 14}, '{255, 15, 144}, '{0,  1,  4},
            '{1,   1,  4}, '{8,   2, 14}, '{9,   3,  24},  '{15, 3, 24},
            '{16,  4, 34}, '{99,  9, 84}, '{100, 10, 94},  '{200, 14, 134}
        };
        seq3 = '{10'h001, 10'h000, 10'h008};
        seq4 = '{10'h001, 10'h000, 10'h050, 10'h0A0, 10'h004, 10'h110,
                 10'h060, 10'h002, 10'h110, 10'h220, 10'h002, 10'h000, 10'h008};

        rstn_i      = 1'b0;
        start_i     = 1'b0;
        dt_i        = 8'd0;
        hold_s_zero = 1'b0;

        step();
        step();
        check("rst_bus_ctrl", int'(bus_ctrl), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_err", int'(err_o), 0);
        rstn_i = 1'b1;
        step();

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].x, vecs[i].r, vecs[i].lat);
            wait_drain(200);
        end

        // x=3: no loop pass, exact control sequence
        launch(3, 1, 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("seq3_%0d", i), int'(bus_ctrl), int'(seq3[i]));
            step();
        end
        wait_drain(10);

        // x=4: one loop pass, exact control sequence
        launch(4, 2, 14);
        check("busy_in_init", int'(busy_o), 1);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("seq4_%0d", i), int'(bus_ctrl), int'(seq4[i]));
            step();
        end
        wait_drain(10);

        // Full sweep against floor(sqrt(x)), minimum result 1
        for (int x = 0; x < 256; x++) begin
            r_exp = isqrt(x);
            if (r_exp < 1) r_exp = 1;
            launch(x, r_exp, 4 + 10 * (r_exp - 1));
            wait_drain(200);
        end

        // start held and re-pulsed during a run; x changed while busy
        d0      = done_cnt;
        dt_i    = 8'd50;
        start_i = 1'b1;
        sb_q.push_back('{50, 7, cyc + 64});
        step();
        dt_i = 8'd200;
        repeat (9) step();
        start_i = 1'b0;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_drain(100);
        repeat (30) step();
        check("single_done", done_cnt - d0, 1);

        // Asynchronous reset in S2
        launch(200, 14, 134);
        n = 0;
        while (bus_ctrl != 10'h060 && n < 60) begin
            step();
            n++;
        end
        check("reach_s2", int'(bus_ctrl), 'h060);
        #2 rstn_i = 1'b0;
        #1;
        check("async_rst_bus_ctrl", int'(bus_ctrl), 0);
        check("async_rst_busy", int'(busy_o), 0);
        sb_q.delete();
        step();
        step();
        rstn_i = 1'b1;
        step();
        launch(4, 2, 14);
        check("post_rst_init", int'(bus_ctrl), 'h001);
        wait_drain(40);

        // Watchdog: s held at zero so the loop never exits
        hold_s_zero = 1'b1;
        e0          = err_cnt;
        d0          = done_cnt;
        dt_i        = 8'd10;
        start_i     = 1'b1;
        t0          = cyc;
        step();
        start_i = 1'b0;
        n = 0;
        while (err_cnt == e0 && n < 300) begin
            step();
            n++;
        end
        check("wd_err_seen", err_cnt - e0, 1);
        check("wd_err_cycle", err_cyc, t0 + 163);
        check("wd_busy_low", int'(busy_o), 0);
        repeat (20) step();
        check("wd_no_done", done_cnt - d0, 0);
        hold_s_zero = 1'b0;

        check("total_err_pulses", err_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sqrt_ctrl.md
Name: sqrt_ctrl

Overview:
- Control FSM for the 8-bit integer square-root unit. It sequences the shared datapath through the 10-bit control bus and reads back the datapath status bus {x, s}.
- It runs the odd-increment algorithm: s=4, d=2; while s<=x { d=d+2; s=s+d+1; }; result r=d>>1.
- It owns the start/busy/done handshake toward the host. The datapath captures dt_i whenever busy_o is low.

Parameters:
- DATA_W, 8, operand width; x field width.
- S_W, 9, accumulator s width (DATA_W+1).
- CTRL_W, 10, control bus width.
- MAX_ITER, 16, watchdog iteration limit; exceeding it aborts with err_o.

Ports:
- clk  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- bus_proc  in  S_W+DATA_W (17)  datapath status: [8:0]=s, [16:9]=x.
- busy_o  out  1  high from the cycle after start is accepted until FIN completes; the datapath freezes x while high.
- bus_ctrl  out  CTRL_W (10)  datapath commands. [0] init; [1] s<=reg1+reg2; [2] d<=reg1+reg2; [3] r/dt_o<=d>>1; [4] reg1<=sel; [5] reg2<=sel; [6] sel=d; [7] sel=const 2; [8] sel=s; [9] sel=const 1.
- done_o  out  1  one-cycle pulse; datapath dt_o is valid in this cycle.
- err_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn_i is asynchronous, active-low. During reset: state=IDLE, busy_o=0, bus_ctrl=0, done_o=0, err_o=0, iteration counter=0.
- Output timing: bus_ctrl is a Moore decode of the current state. busy_o, done_o and err_o are registered.
- Select rule: at most one of bus_ctrl[9:6] is set in any state. bus_ctrl is 0 in IDLE.
- States: IDLE, INIT, CMP, D1, D2, D3, S1, S2, S3, S4, S5, S6, FIN.
- IDLE: start_i=1 -> INIT and busy_o<=1. x is captured by the datapath on this same edge, so dt_i must be valid in the start cycle. start_i in any other state is ignored.
- INIT: bus_ctrl=0x001 -> CMP; iteration counter<=0.
- CMP: if s > {1'b0,x} -> FIN. Otherwise -> D1 with counter+1. If the counter already equals MAX_ITER -> IDLE with err_o=1, busy_o=0, no done_o.
- D1 0x050 (sel d, load reg1) -> D2 0x0A0 (sel 2, load reg2) -> D3 0x004 (d<=sum).
- S1 0x110 (sel s, load reg1) -> S2 0x060 (sel d, load reg2) -> S3 0x002 (s<=sum).
- S4 0x110 -> S5 0x220 (sel 1, load reg2) -> S6 0x002 -> CMP.
- The compare uses the s value updated by the previous S6 edge.
- FIN: bus_ctrl=0x008 -> IDLE; done_o<=1 and busy_o<=0 on the same edge.
- Latency: start sampled at T0; k loop iterations; done_o high at T0+4+10k.
- Width rules: s compared as 9-bit unsigned against zero-extended x. The controller performs no arithmetic other than the iteration counter (clog2(MAX_ITER+1) bits).
- Edge values: x=0 yields r=1, which is algorithm-defined and not an error. x=255 gives k=14 and r=15.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The datapath re-inits on the next INIT.
- done_o and err_o are never both high.

Decomposition:
- Shared package sqrt_pkg holds:
  - the state enum type;
  - bus_ctrl bit-index constants (CTRL_INIT, CTRL_LD_S, CTRL_LD_D, CTRL_OUT, CTRL_LD_R1, CTRL_LD_R2, CTRL_SEL_D, CTRL_SEL_2, CTRL_SEL_S, CTRL_SEL_1);
  - status field slice constants;
  - CTRL_W, S_W, DATA_W.
- No sub-module: a single FSM plus iteration counter. The bench pairs this block with the existing datapath.

Test Plan:
- Reset with rstn_i=0 mid-iteration (state S2) -> bus_ctrl=0, busy_o=0 asynchronously; next start runs cleanly from INIT.
- start_i with dt_i=3 -> k=0, bus_ctrl sequence 0x001, 0x000, 0x008; done_o at T0+4; dt_o=1.
- dt_i=4 -> k=1; exact 10-state bus_ctrl sequence checked per cycle; done_o at T0+14; dt_o=2.
- dt_i=255 -> done_o at T0+144, dt_o=15. Also sweep x=0..255 against floor(sqrt(x)), with x=0 expecting 1.
- Standalone bench holds bus_proc s-field at 0 -> err_o pulse after MAX_ITER=16 iterations, no done_o, busy_o=0.
- start_i held high through a run and pulsed again mid-run -> exactly one done_o; x changes during busy are not captured.
